hfg_window_scheduler: RTL

HFG_WINDOW_SCHEDULER -- requirements
Module: hfg_window_scheduler

---
 rtl/hfg_pkg.sv | 15 +
 rtl/hfg_win_counter.sv | 56 +++++
 rtl/hfg_window_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hfg_pkg.sv
// Shared types and constants for the HFG window scheduler.
package hfg_pkg;
  localparam int COORD_W  = 9;
  localparam int WIN_DEF  = 19;
  localparam int STEP_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CLS,
    S_STEP,
    S_DONE
  } state_t;
endpackage

// File: rtl/hfg_win_counter.sv
// X/Y stride counters for the detection window, with flags that say whether
// another stride along each axis would push the window off the image.
module hfg_win_counter
  import hfg_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int WIN   = WIN_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               x_last_o,
  output logic               y_last_o
);
  localparam logic [31:0] X_MAX = 32'(IMG_W - WIN);
  localparam logic [31:0] Y_MAX = 32'(IMG_H - WIN);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  // Limit test done in 32 bits so the 9-bit coordinate can never wrap.
  assign x_last_o = ({{(32-COORD_W){1'b0}}, x_q} + 32'(STEP)) > X_MAX;
  assign y_last_o = ({{(32-COORD_W){1'b0}}, y_q} + 32'(STEP)) > Y_MAX;
  assign x_o = x_q;
  assign y_o = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (!x_last_o) begin
        x_d = x_q + COORD_W'(STEP);
      end else if (!y_last_o) begin
        x_d = '0;
        y_d = y_q + COORD_W'(STEP);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/hfg_window_scheduler.sv
// Raster scan of detection windows: load -> feature run -> classify -> step.
// Optional RUN watchdog with sticky oError under HFG_SCHED_WATCHDOG_EN.
module hfg_window_scheduler
  import hfg_pkg::*;
#(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int WIN     = WIN_DEF,
  parameter int STEP    = STEP_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic               iIIBG_Valid,
  input  logic               iFull_FBR,
  input  logic               iCls_Ack,
  output logic               oHFG_Ready,
  output logic               oHFG_Run,
  output logic               oCls_Req,
  output logic [COORD_W-1:0] oWin_X,
  output logic [COORD_W-1:0] oWin_Y,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);
  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   cnt_clr, cnt_adv, x_last, y_last;
  logic   wd_fire;

  hfg_win_counter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STEP(STEP)
  ) u_win_counter (
    .clk_i   (iClk),
    .rst_i   (iReset),
    .clr_i   (cnt_clr),
    .adv_i   (cnt_adv),
    .x_o     (oWin_X),
    .y_o     (oWin_Y),
    .x_last_o(x_last),
    .y_last_o(y_last)
  );

`ifdef HFG_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Count of completed RUN cycles; fires on the cycle that would make it TIMEOUT.
  assign wd_fire = (wd_q == WD_W'(TIMEOUT - 1));
  assign oError  = err_q;

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == S_LOAD) wd_d = '0;
    else if (state_q == S_RUN) wd_d = wd_q + WD_W'(1);
    if (!iAbort && state_q == S_RUN && !iFull_FBR && wd_fire) err_d = 1'b1;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign wd_fire        = 1'b0;
  assign oError         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    if (iAbort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (iStart) begin
          state_d = S_LOAD;
          cnt_clr = 1'b1;
        end
        S_LOAD: if (iIIBG_Valid) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
        S_RUN: begin
          if (iFull_FBR) state_d = S_CLS;
          else if (wd_fire) state_d = S_STEP;
        end
        S_CLS:  if (iCls_Ack) state_d = S_STEP;
        S_STEP: begin
          if (x_last && y_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            cnt_adv = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  assign oHFG_Ready = ready_q;
  assign oHFG_Run   = (state_q == S_RUN);
  assign oCls_Req   = (state_q == S_CLS);
  assign oDone      = (state_q == S_DONE);
  assign oBusy      = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule
